// File: rtl/hex_counter_4digit.sv
// Four-digit run/stop up/down counter feeding per-digit 7-segment decoders.
// Buttons are synchronized and edge-detected here; a prescaler sets the count rate.
module hex_counter_4digit #(
  parameter int DIV  = 5_000_000,
  parameter int BASE = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_ss,
  input  logic        btn_clr,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] digits,
  output logic        running,
  output logic        ovf
);

  localparam int NUM_DIG = 4;
  localparam int PW      = $clog2(DIV);
  localparam logic [3:0]    TOP  = 4'(BASE - 1);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam int SS  = 0;
  localparam int CLR = 1;

  typedef enum logic {STOP, RUN} state_t;

  state_t                      state;
  logic [PW-1:0]               presc;
  logic [1:0][1:0]             sync;
  logic [1:0]                  prev;
  logic [1:0]                  rise;
  logic [NUM_DIG-1:0][3:0]     dig_q;
  logic [NUM_DIG-1:0][3:0]     dig_nxt;
  logic [NUM_DIG-1:0][3:0]     ld_clamp;
  logic                        wrap;
  logic                        tick;

  assign digits = dig_q;
  assign tick   = (state == RUN) && (presc == PMAX);

  // Out-of-radix load nibbles saturate at the top digit value.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_clamp
    assign ld_clamp[g] = (load_val[g*4 +: 4] > TOP) ? TOP : load_val[g*4 +: 4];
  end

  always_comb begin
    logic c;
    c       = 1'b1;
    dig_nxt = dig_q;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (c) begin
        if (up) begin
          if (dig_q[i] == TOP) dig_nxt[i] = 4'd0;
          else begin
            dig_nxt[i] = dig_q[i] + 4'd1;
            c          = 1'b0;
          end
        end else begin
          if (dig_q[i] == 4'd0) dig_nxt[i] = TOP;
          else begin
            dig_nxt[i] = dig_q[i] - 4'd1;
            c          = 1'b0;
          end
        end
      end
    end
    wrap = c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= '0;
      prev    <= '0;
      rise    <= '0;
      state   <= STOP;
      running <= 1'b0;
      presc   <= '0;
      dig_q   <= '0;
      ovf     <= 1'b0;
    end else begin
      sync <= {sync[0], {btn_clr, btn_ss}};
      prev <= sync[1];
      rise <= sync[1] & ~prev;
      ovf  <= 1'b0;
      if (rise[CLR]) begin
        dig_q   <= '0;
        presc   <= '0;
        state   <= STOP;
        running <= 1'b0;
      end else if (load) begin
        dig_q <= ld_clamp;
        presc <= '0;
      end else if (rise[SS]) begin
        // Entering RUN restarts the tick period; pausing keeps the phase.
        if (state == STOP) begin
          state   <= RUN;
          running <= 1'b1;
          presc   <= '0;
        end else begin
          state   <= STOP;
          running <= 1'b0;
        end
      end else if (state == RUN) begin
        if (tick) begin
          presc <= '0;
          dig_q <= dig_nxt;
          ovf   <= wrap;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_counter_4digit.sv
// Directed bench: BCD and hex instances share stimulus; table of loads plus timed sequences.
module tb_hex_counter_4digit;

  logic        clk = 1'b0;
  logic        rst_n, btn_ss, btn_clr, up, load;
  logic [15:0] load_val;
  logic [15:0] d10, d16;
  logic        r10, r16, o10, o16;

  hex_counter_4digit #(.DIV(4), .BASE(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr), .up(up),
    .load(load), .load_val(load_val), .digits(d10), .running(r10), .ovf(o10));

  hex_counter_4digit #(.DIV(4), .BASE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr), .up(up),
    .load(load), .load_val(load_val), .digits(d16), .running(r16), .ovf(o16));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] val;
    logic [15:0] exp10;
    logic [15:0] exp16;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int tog;
    logic prv;

    vecs[0] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{16'h1234, 16'h1234, 16'h1234};
    vecs[2] = '{16'hA5F3, 16'h9593, 16'hA5F3};
    vecs[3] = '{16'hFFFF, 16'h9999, 16'hFFFF};
    vecs[4] = '{16'h9AB0, 16'h9990, 16'h9AB0};
    vecs[5] = '{16'h0C0D, 16'h0909, 16'h0C0D};

    rst_n = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    step(2);
    chk("rst_digits10", d10, 16'h0000);
    chk("rst_digits16", d16, 16'h0000);
    chk("rst_running", {15'd0, r10}, 16'd0);
    chk("rst_ovf", {15'd0, o10}, 16'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      step(1);
      if (d10 !== 16'h0000 || r10 !== 1'b0 || o10 !== 1'b0 || d16 !== 16'h0000) bad++;
    end
    chk("idle_stable", 16'(bad), 16'd0);

    // Loads while stopped, including radix clamping
    for (int i = 0; i < 6; i++) begin
      load_val = vecs[i].val; load = 1'b1;
      step(1);
      load = 1'b0;
      chk($sformatf("load10_%0d", i), d10, vecs[i].exp10);
      chk($sformatf("load16_%0d", i), d16, vecs[i].exp16);
      chk($sformatf("load_run_%0d", i), {15'd0, r10}, 16'd0);
    end
    load_val = 16'h0000; load = 1'b1; step(1); load = 1'b0;

    // Start and count up
    btn_ss = 1'b1;
    step(3);  chk("run_early", {15'd0, r10}, 16'd0);
    step(1);  chk("run_4th", {15'd0, r10}, 16'd1);
    step(3);  chk("cnt_pre1", d10, 16'h0000);
    step(1);  chk("cnt_1", d10, 16'h0001);
    step(3);  chk("cnt_pre2", d10, 16'h0001);
    step(1);  chk("cnt_2", d10, 16'h0002);
    btn_ss = 1'b0;

    // Up wrap 9998 -> 9999 -> 0000
    load_val = 16'h9998; load = 1'b1; step(1); load = 1'b0;
    chk("ld9998", d10, 16'h9998);
    step(4);  chk("up_9999", d10, 16'h9999);
    step(3);  chk("ovf_pre", {15'd0, o10}, 16'd0);
    step(1);
    chk("up_wrap10", d10, 16'h0000);
    chk("ovf_wrap10", {15'd0, o10}, 16'd1);
    chk("up_hex_999a", d16, 16'h999A);
    chk("ovf16_none", {15'd0, o16}, 16'd0);
    step(1);
    chk("ovf_1cyc", {15'd0, o10}, 16'd0);
    chk("wrap_hold", d10, 16'h0000);

    // Down wrap from 0000
    up = 1'b0; load_val = 16'h0000; load = 1'b1; step(1); load = 1'b0;
    step(4);
    chk("dn_wrap10", d10, 16'h9999);
    chk("dn_ovf10", {15'd0, o10}, 16'd1);
    chk("dn_wrap16", d16, 16'hFFFF);
    chk("dn_ovf16", {15'd0, o16}, 16'd1);
    step(1);  chk("dn_ovf_end", {15'd0, o10}, 16'd0);

    // Load on the tick edge: tick discarded, period restarts
    step(2);
    load_val = 16'h1234; load = 1'b1; step(1); load = 1'b0;
    chk("ldtick10", d10, 16'h1234);
    chk("ldtick16", d16, 16'h1234);
    chk("ldtick_ovf", {15'd0, o10}, 16'd0);
    step(3);  chk("ldtick_hold", d10, 16'h1234);
    step(1);
    chk("ldtick_next10", d10, 16'h1233);
    chk("ldtick_next16", d16, 16'h1233);

    // Simultaneous start/stop and clear while running
    btn_ss = 1'b1; btn_clr = 1'b1;
    step(3);  chk("clr_pre_run", {15'd0, r10}, 16'd1);
    step(1);
    chk("clr_digits10", d10, 16'h0000);
    chk("clr_digits16", d16, 16'h0000);
    chk("clr_run", {15'd0, r10}, 16'd0);
    btn_ss = 1'b0; btn_clr = 1'b0;
    step(5);

    // Held button: exactly one toggle
    up = 1'b1; btn_ss = 1'b1;
    tog = 0; prv = r10;
    repeat (50) begin
      step(1);
      if (r10 !== prv) tog++;
      prv = r10;
    end
    chk("held_toggles", 16'(tog), 16'd1);
    chk("held_run", {15'd0, r10}, 16'd1);
    btn_ss = 1'b0;

    // Pause keeps the count; resume restarts the tick period
    btn_clr = 1'b1; step(4); btn_clr = 1'b0;
    chk("clr2", d10, 16'h0000);
    step(3);
    btn_ss = 1'b1;
    step(4);  chk("p_run", {15'd0, r10}, 16'd1);
    btn_ss = 1'b0;
    step(3);  btn_ss = 1'b1;
    step(1);  chk("p_cnt1", d10, 16'h0001);
    step(3);  chk("p_stop", {15'd0, r10}, 16'd0);
    btn_ss = 1'b0;
    step(20);
    chk("p_frozen", d10, 16'h0001);
    chk("p_still", {15'd0, r10}, 16'd0);
    btn_ss = 1'b1;
    step(4);  chk("r_run", {15'd0, r10}, 16'd1);
    btn_ss = 1'b0;
    step(3);  chk("r_pre", d10, 16'h0001);
    step(1);  chk("r_cnt2", d10, 16'h0002);

    // Reset mid-count
    rst_n = 1'b0; step(1);
    chk("mrst_digits", d10, 16'h0000);
    chk("mrst_run", {15'd0, r10}, 16'd0);
    chk("mrst_ovf", {15'd0, o10}, 16'd0);
    rst_n = 1'b1;
    step(10);
    chk("mrst_idle", d10, 16'h0000);
    chk("mrst_stop", {15'd0, r10}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
